// File: rtl/div_ring_sequencer.sv
// div_ring_sequencer: shares one restoring divider across the rotating pairs A/B, B/C, C/D, D/A
module div_ring_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     C,
  input  logic [WIDTH-1:0]     D,
  input  logic [3:0]           pair_en,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           cur_pair,
  output logic [4*WIDTH-1:0]   quot,
  output logic [4*WIDTH-1:0]   rem,
  output logic [3:0]           error
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, CHECK, DIV, STORE, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ops [4];
  logic [WIDTH-1:0] qr [4];
  logic [WIDTH-1:0] rr [4];
  logic [3:0] en;
  logic [1:0] idx;
  logic [WIDTH:0] r, r_sh;
  logic [WIDTH-1:0] q, dvd, dvs;
  logic [CW-1:0] cnt;
  logic ge, last, skip;
  // pair i divides operand i by operand i+1, wrapping D back to A
  assign dvd = ops[idx];
  assign dvs = ops[idx + 2'd1];
  assign r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
  assign ge = r_sh >= {1'b0, dvs};
  assign last = cnt == CW'(WIDTH - 1);
  assign skip = !en[idx] || dvs == '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign cur_pair = idx;
  assign quot = {qr[3], qr[2], qr[1], qr[0]};
  assign rem = {rr[3], rr[2], rr[1], rr[0]};
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = start ? CHECK : IDLE;
    else if (state == CHECK) state_n = !skip ? DIV : idx == 2'd3 ? DONE : CHECK;
    else if (state == DIV) state_n = last ? STORE : DIV;
    else if (state == STORE) state_n = idx == 2'd3 ? DONE : CHECK;
    else state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ops <= '{default: '0};
      qr <= '{default: '0};
      rr <= '{default: '0};
      en <= '0;
      idx <= '0;
      r <= '0;
      q <= '0;
      cnt <= '0;
      error <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ops <= '{A, B, C, D};
          en <= pair_en;
          qr <= '{default: '0};
          rr <= '{default: '0};
          error <= '0;
          idx <= '0;
        end
        CHECK: begin
          if (skip) idx <= idx + 2'd1;
          if (en[idx] && dvs == '0) begin
            qr[idx] <= '1;
            rr[idx] <= dvd;
            error[idx] <= 1'b1;
          end
          r <= '0;
          q <= dvd;
          cnt <= '0;
        end
        DIV: begin
          r <= ge ? r_sh - {1'b0, dvs} : r_sh;
          q <= {q[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
        end
        STORE: begin
          qr[idx] <= q;
          rr[idx] <= r[WIDTH-1:0];
          error[idx] <= 1'b0;
          idx <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_ring_sequencer.sv
// tb_div_ring_sequencer: directed and random runs checked against a plain-arithmetic model
module tb_div_ring_sequencer;
  localparam int W = 8;
  logic clk = 0, rst = 1, start = 0;
  logic [W-1:0] A = 0, B = 0, C = 0, D = 0;
  logic [3:0] pair_en = 0;
  logic busy, done;
  logic [1:0] cur_pair;
  logic [4*W-1:0] quot, rem;
  logic [3:0] error;
  int checks = 0, errors = 0;

  div_ring_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .C(C), .D(D),
    .pair_en(pair_en), .busy(busy), .done(done), .cur_pair(cur_pair),
    .quot(quot), .rem(rem), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [W-1:0] a, b, c, d, input logic [3:0] e, input bit disturb, input string tag);
    logic [W-1:0] ops [4];
    logic [W-1:0] x, y;
    logic [31:0] eq, er;
    logic [3:0] ee;
    int cost, n, dones;
    ops = '{a, b, c, d};
    eq = 0; er = 0; ee = 0; cost = 0;
    for (int i = 0; i < 4; i++) begin
      x = ops[i];
      y = ops[(i + 1) % 4];
      if (!e[i]) cost += 1;
      else if (y == 0) begin
        eq[i*W +: W] = '1; er[i*W +: W] = x; ee[i] = 1'b1; cost += 1;
      end else begin
        eq[i*W +: W] = x / y; er[i*W +: W] = x % y; cost += W + 2;
      end
    end
    @(negedge clk);
    A = a; B = b; C = c; D = d; pair_en = e; start = 1;
    @(posedge clk); #1 start = 0;
    chk({tag, " cur_pair0"}, 32'(cur_pair), 0);
    n = 0; dones = 0;
    while (n < 200 && done !== 1'b1) begin
      chk({tag, " busy"}, 32'(busy), 1);
      @(posedge clk); #1;
      n++;
      if (disturb && n == 5) begin
        A = 0; B = 0; C = 0; D = 0; start = 1;
      end else if (n == 6) start = 0;
      if (!disturb && n == 2) begin
        A = W'($urandom); B = W'($urandom); C = W'($urandom); D = W'($urandom); pair_en = 4'($urandom);
      end
      if (e == 0 && n < 4) chk({tag, " cur_pair step"}, 32'(cur_pair), 32'(n));
    end
    chk({tag, " latency"}, 32'(n), 32'(cost));
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " busy_done"}, 32'(busy), 1);
    chk({tag, " quot"}, quot, eq);
    chk({tag, " rem"}, rem, er);
    chk({tag, " error"}, 32'(error), 32'(ee));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk({tag, " done_after"}, 32'(done), 0);
      chk({tag, " busy_after"}, 32'(busy), 0);
    end
    chk({tag, " quot_hold"}, quot, eq);
    chk({tag, " rem_hold"}, rem, er);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset cur_pair", 32'(cur_pair), 0);
    chk("reset quot", quot, 0);
    chk("reset rem", rem, 0);
    chk("reset error", 32'(error), 0);
    run(12, 8, 12, 12, 4'b1111, 0, "T1");
    run(0, 8, 12, 0, 4'b1111, 0, "T2");
    run(222, 18, 255, 16, 4'b0101, 0, "T3");
    run(156, 252, 12, 1, 4'b1111, 1, "T4");
    @(negedge clk);
    A = 12; B = 8; C = 12; D = 12; pair_en = 4'b1111; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (11) @(posedge clk);
    #1;
    chk("T5 cur_pair mid", 32'(cur_pair), 1);
    chk("T5 busy mid", 32'(busy), 1);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("T5 busy", 32'(busy), 0);
    chk("T5 done", 32'(done), 0);
    chk("T5 quot", quot, 0);
    chk("T5 rem", rem, 0);
    chk("T5 error", 32'(error), 0);
    run(12, 8, 12, 12, 4'b1111, 0, "T5 rerun");
    run(0, 0, 0, 0, 4'b0000, 0, "T6");
    run(255, 1, 255, 255, 4'b1111, 0, "div1");
    for (int t = 0; t < 20; t++) begin
      logic [W-1:0] v [4];
      for (int i = 0; i < 4; i++)
        v[i] = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 2)) : W'($urandom);
      run(v[0], v[1], v[2], v[3], 4'($urandom), 0, "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_ring_sequencer.md
Name: div_ring_sequencer

Overview:
- Sequencer that shares one iterative restoring divider across the four rotating operand pairs of the divide selector: pair 0 = A/B, pair 1 = B/C, pair 2 = C/D, pair 3 = D/A.
- On start, latches A..D and walks pairs 0..3 in order.
- Each enabled pair gets a quotient, a remainder and a divide-by-zero flag. A single done pulse follows the last pair.
- Sits beside the combinational selector as its multi-cycle, area-shared replacement.

Parameters:
- WIDTH, 8, operand/quotient/remainder width; also the number of DIV cycles per pair.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous and active-high
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  operand
- B  input  WIDTH  operand
- C  input  WIDTH  operand
- D  input  WIDTH  operand
- pair_en  input  4  bit i enables pair i; sampled with start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- cur_pair  output  2  index of the pair being processed; 0 in IDLE
- quot  output  4*WIDTH  quot[i*WIDTH +: WIDTH] = quotient of pair i
- rem  output  4*WIDTH  rem[i*WIDTH +: WIDTH] = remainder of pair i
- error  output  4  error[i] = divisor of pair i was zero

Behaviour:
- Reset: rst high at a clock edge → state IDLE; busy, done, cur_pair, quot, rem, error all 0; internal registers cleared. Reset overrides everything, including mid-operation, and discards partial results.
- States: IDLE, CHECK, DIV, STORE, DONE (one-hot or binary is implementer's choice). Outputs are registered or decoded from state only; no input-to-output combinational path.
- IDLE:
  - If start=1: latch A..D and pair_en, clear quot/rem/error to 0, set pair index 0, go to CHECK.
  - If start=0: stay in IDLE.
- CHECK, pair i (dividend/divisor taken from latched copies):
  - pair_en[i]=0: results for i stay 0, error[i]=0. Advance (cost 1 cycle).
  - Divisor == 0: quot_i = all ones, rem_i = dividend, error[i]=1. Advance (cost 1 cycle).
  - Otherwise: partial remainder R (WIDTH+1 bits) = 0, Q = dividend, step counter = 0, go to DIV.
- DIV: one restoring step per cycle for exactly WIDTH cycles.
  - Shift {R,Q} left by 1.
  - If R ≥ divisor: R -= divisor and Q[0]=1; else Q[0]=0.
  - After step WIDTH-1, go to STORE.
- STORE: write Q and R[WIDTH-1:0] into slot i, error[i]=0, then advance.
- Advance:
  - If i == 3, go to DONE.
  - Otherwise i = i+1 and go to CHECK.
- DONE: done=1 and busy=1 for this single cycle, then go to IDLE.
- Cost per pair: 1 cycle if disabled or zero divisor; WIDTH+2 cycles otherwise.
- Latency: done rises Σcost clock edges after the edge that sampled start.
  - With WIDTH=8, all pairs enabled and nonzero: 40 edges.
  - Minimum: 4 edges.
- Result lifetime: quot/rem/error hold their values from DONE until the next accepted start clears them. Partial values are visible while busy, but are valid only from the done pulse onward.
- Input timing:
  - start while busy (including the DONE cycle) is ignored; no queuing.
  - Changes to A..D or pair_en while busy have no effect on the current run.
- Arithmetic: unsigned. Quotient equals floor(dividend/divisor) and remainder equals dividend mod divisor for every nonzero divisor, including divisor > dividend (quotient 0, remainder = dividend) and divisor 1.
- Back-to-back: start held high continuously produces one run per IDLE visit. The next run begins on the edge after DONE.

Test Plan:
- T1: A=12 B=8 C=12 D=12, pair_en=1111, start for 1 cycle → done exactly 40 edges later; quot={1,1,0,1} for pairs 3..0; rem={0,0,8,4} for pairs 3..0; error=0000; busy high 41 cycles.
- T2: A=0 B=8 C=12 D=0, pair_en=1111 → pair0 quot 0 rem 0; pair1 quot 0 rem 8; pair2 quot FF rem 12; pair3 quot FF rem 0; error=1100; done after 22 edges.
- T3: A=222 B=18 C=255 D=16, pair_en=0101 → pair0 quot 12 rem 6; pair2 quot 15 rem 15; pairs 1 and 3 all zero; error=0000; done after 22 edges.
- T4: A=156 B=252 C=12 D=1, start; 5 cycles later drive A=0, B=0, C=0, D=0 and pulse start again → run unaffected and no second run starts. Pair0 quot 0 rem 156; pair1 quot 21 rem 0; pair2 quot 12 rem 0; pair3 quot 0 rem 1; exactly one done pulse.
- T5: start with T1 operands; assert rst for 1 cycle while cur_pair=1 in DIV → next cycle busy=0, done=0, all results 0. A fresh start with T1 operands then reproduces the T1 results at 40 edges.
- T6: pair_en=0000, start → done after 4 edges; all outputs 0; cur_pair steps 0,1,2,3.
